// File: rtl/vdp_pkg.sv
// vdp_pkg: shared constants and types for the video display path
package vdp_pkg;
  localparam logic [7:0] SPI_READ = 8'h03;
  localparam int         VADR_W   = 18;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
endpackage

// File: rtl/spi_shift16.sv
// spi_shift16: mode-0 clk/2 SPI engine shifting a 32-bit command out and 16-bit words in
module spi_shift16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic        cmd_phase,
  input  logic [31:0] cmd,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        cmd_last,
  output logic        word_valid,
  output logic [15:0] word
);
  logic        sck_q, sck_d, wv_q, wv_d, fall;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  always_comb begin
    fall     = en && sck_q;
    sck_d    = en && !sck_q;
    tx_d     = load ? cmd : fall ? {tx_q[30:0], 1'b0} : tx_q;
    rx_d     = (fall && !cmd_phase) ? {rx_q[14:0], miso} : rx_q;
    cnt_d    = load ? 5'd0 : fall ? cnt_q + 5'd1 : cnt_q;
    cmd_last = fall && cmd_phase && cnt_q == 5'd31;
    wv_d     = fall && !cmd_phase && cnt_q[3:0] == 4'hF;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
      wv_q  <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      sck_q <= sck_d;
      wv_q  <= wv_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end
  assign sck        = sck_q;
  assign mosi       = tx_q[31];
  assign word_valid = wv_q;
  assign word       = rx_q;
endmodule

// File: rtl/flash_vram_loader.sv
// flash_vram_loader: boot-time copier streaming an SPI NOR image into video SRAM
module flash_vram_loader
  import vdp_pkg::*;
#(
  parameter logic [23:0]       FLASH_ADDR = 24'h100000,
  parameter logic [VADR_W-1:0] VRAM_BASE  = 18'h00000,
  parameter logic [18:0]       WORDS      = 19'd172800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              flash_sck,
  output logic              flash_ss,
  output logic              flash_mosi,
  input  logic              flash_miso,
  output logic [VADR_W-1:0] v_adr,
  output logic [15:0]       v_dat_o,
  output logic              v_we,
  output logic              v_oe_pin,
  output logic              v_oe_sram
);
  state_t            state_q, state_d;
  logic [1:0]        ws_q, ws_d;
  logic [18:0]       wcnt_q, wcnt_d;
  logic [VADR_W-1:0] adr_q, adr_d;
  logic [15:0]       dat_q, dat_d, word;
  logic              we_q, we_d, oep_q, oep_d, oes_q, oes_d;
  logic              accept, active, cmd_last, word_valid;
  assign active = state_q == CMD || state_q == DATA;
  spi_shift16 u_spi (
    .clk(clk),
    .rst_n(rst_n),
    .en(active),
    .load(accept),
    .cmd_phase(state_q == CMD),
    .cmd({SPI_READ, FLASH_ADDR}),
    .miso(flash_miso),
    .sck(flash_sck),
    .mosi(flash_mosi),
    .cmd_last(cmd_last),
    .word_valid(word_valid),
    .word(word)
  );
  always_comb begin
    accept  = start && state_q == IDLE;
    state_d = accept ? CMD
            : (state_q == CMD && cmd_last) ? DATA
            : (ws_q == 2'd3 && wcnt_q == WORDS) ? DONE
            : (state_q == DONE) ? IDLE : state_q;
    ws_d    = word_valid ? 2'd1 : (ws_q == 2'd0) ? 2'd0 : ws_q + 2'd1;
    wcnt_d  = accept ? 19'd0 : word_valid ? wcnt_q + 19'd1 : wcnt_q;
    adr_d   = word_valid ? VRAM_BASE + wcnt_q[VADR_W-1:0] : adr_q;
    dat_d   = word_valid ? word : dat_q;
    we_d    = ws_q == 2'd1;
    oep_d   = word_valid || (oep_q && ws_q != 2'd3);
    oes_d   = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ws_q    <= 2'd0;
      wcnt_q  <= '0;
      adr_q   <= VRAM_BASE;
      dat_q   <= '0;
      we_q    <= 1'b0;
      oep_q   <= 1'b0;
      oes_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      oep_q   <= oep_d;
      oes_q   <= oes_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign flash_ss  = !active;
  assign v_adr     = adr_q;
  assign v_dat_o   = dat_q;
  assign v_we      = we_q;
  assign v_oe_pin  = oep_q;
  assign v_oe_sram = oes_q;
endmodule

// File: tb/tb_flash_vram_loader.sv
// tb_flash_vram_loader: scoreboard bench with flash model and bus protocol monitor
module tb_flash_vram_loader;
  localparam logic [23:0] FA       = 24'h100000;
  localparam logic [17:0] VB       = 18'h3FFFF;
  localparam int          NW       = 3;
  localparam int          DONE_CYC = 32 * NW + 69;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flash_miso;
  logic        busy, done, flash_sck, flash_ss, flash_mosi, v_we, v_oe_pin, v_oe_sram;
  logic [17:0] v_adr;
  logic [15:0] v_dat_o;
  int          n_tests = 0, n_fail = 0, nwr = 0, ndone = 0, ncmd = 0, nb = 0, n = 0;
  logic [33:0] exp_q[$];
  logic [31:0] cmd_sh = '0;
  logic        pwe = 1'b0, poep = 1'b0, psck = 1'b0, pss = 1'b1, pmosi = 1'b0;
  logic [17:0] padr = '0;
  logic [15:0] pdat = '0;
  flash_vram_loader #(.FLASH_ADDR(FA), .VRAM_BASE(VB), .WORDS(19'(NW))) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .flash_sck(flash_sck),
    .flash_ss(flash_ss),
    .flash_mosi(flash_mosi),
    .flash_miso(flash_miso),
    .v_adr(v_adr),
    .v_dat_o(v_dat_o),
    .v_we(v_we),
    .v_oe_pin(v_oe_pin),
    .v_oe_sram(v_oe_sram)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] fbyte(input int j);
    return 8'h12 + 8'(j) * 8'h22;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge flash_ss);
    nb = 0;
  end
  initial begin
    logic [7:0] b;
    flash_miso = 1'b0;
    forever begin
      @(flash_sck);
      if (!flash_ss) begin
        if (flash_sck) begin
          if (nb < 32) cmd_sh = {cmd_sh[30:0], flash_mosi};
        end else begin
          nb++;
          if (nb == 32) begin
            ncmd++;
            check("read_command", 64'(cmd_sh), 64'({8'h03, FA}));
          end
          #1;
          if (nb >= 32) begin
            b = fbyte((nb - 32) / 8);
            flash_miso = b[3'(7 - (nb - 32) % 8)];
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (flash_ss) check("sck_with_ss_high", 64'(flash_sck), 64'd0);
      else if (!pss) check("sck_period", 64'(flash_sck), 64'(!psck));
      if (flash_sck) check("mosi_stable", 64'(flash_mosi), 64'(pmosi));
      if (v_we && !pwe) begin
        nwr++;
        check("oe_pin_before_we", 64'(poep), 64'd1);
        check("addr_setup", 64'(v_adr), 64'(padr));
        check("data_setup", 64'(v_dat_o), 64'(pdat));
        if (exp_q.size() > 0) check("sram_write", 64'({v_adr, v_dat_o}), 64'(exp_q.pop_front()));
      end
      if (pwe && !v_we) begin
        check("oe_pin_after_we", 64'(v_oe_pin), 64'd1);
        check("addr_hold", 64'(v_adr), 64'(padr));
        check("data_hold", 64'(v_dat_o), 64'(pdat));
      end
      if (done) ndone++;
    end
    pwe   = v_we;
    poep  = v_oe_pin;
    psck  = flash_sck;
    pss   = flash_ss;
    pmosi = flash_mosi;
    padr  = v_adr;
    pdat  = v_dat_o;
  end
  task automatic transfer(input int restart_at, input int abort_at);
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back({VB + 18'(i), fbyte(2 * i), fbyte(2 * i + 1)});
    nwr   = 0;
    ndone = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n     = 1;
    check("ss_cycle1", 64'(flash_ss), 64'd0);
    check("busy_cycle1", 64'(busy), 64'd1);
    check("oe_sram_cycle1", 64'(v_oe_sram), 64'd0);
    check("mosi_cycle1", 64'(flash_mosi), 64'd0);
    check("sck_cycle1", 64'(flash_sck), 64'd0);
    while (!done && n < DONE_CYC + 50 && n != abort_at) begin
      start = (n == restart_at);
      tick();
      n++;
    end
    start = 1'b0;
  endtask
  task automatic finish_checks();
    check("done_cycle", 64'(n), 64'(DONE_CYC));
    check("ss_at_done", 64'(flash_ss), 64'd1);
    check("busy_at_done", 64'(busy), 64'd1);
    tick();
    check("busy_after_done", 64'(busy), 64'd0);
    check("oe_sram_after_done", 64'(v_oe_sram), 64'd1);
    check("done_one_cycle", 64'(done), 64'd0);
    repeat (5) tick();
    check("write_count", 64'(nwr), 64'(NW));
    check("done_pulses", 64'(ndone), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ss", 64'(flash_ss), 64'd1);
    check("rst_sck", 64'(flash_sck), 64'd0);
    check("rst_mosi", 64'(flash_mosi), 64'd0);
    check("rst_adr", 64'(v_adr), 64'(VB));
    check("rst_dat", 64'(v_dat_o), 64'd0);
    check("rst_we", 64'(v_we), 64'd0);
    check("rst_oe_pin", 64'(v_oe_pin), 64'd0);
    check("rst_oe_sram", 64'(v_oe_sram), 64'd1);
    rst_n = 1'b1;
    repeat (2) tick();
    transfer(40, -1);
    finish_checks();
    transfer(-1, 80);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss", 64'(flash_ss), 64'd1);
    check("abort_we", 64'(v_we), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_oe_sram", 64'(v_oe_sram), 64'd1);
    check("abort_sck", 64'(flash_sck), 64'd0);
    check("abort_writes", 64'(nwr), 64'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    transfer(-1, -1);
    finish_checks();
    check("command_count", 64'(ncmd), 64'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
